// File: rtl/iic_shield_arbiter.sv
// -----------------------------------------------------------------------------
// iic_shield_arbiter
//
// Shares the Arduino-shield IIC pad pair (SCL/SDA IOBUFs) between NUM_REQ
// internal IIC masters. A round-robin arbiter hands the bus to one master only
// after the bus has been idle (SCL=SDA=1) for BUS_FREE_CYCLES. The owner's
// open-drain controls are muxed onto the pads. A grant is revoked if the owner
// holds SCL low for TIMEOUT_CYCLES.
//
// Optional feature macro: IIC_BUS_RECOVERY_EN
//   When defined, a revoked transfer that leaves SDA stuck low is followed by
//   up to 9 SCL recovery pulses and a STOP before the bus is re-qualified.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req[NUM_REQ]             per-master request (level, held for the transfer)
//   gnt[NUM_REQ]             one-hot registered grant
//   m_scl_o/m_scl_t          per-master SCL value / tristate (1 = release)
//   m_sda_o/m_sda_t          per-master SDA value / tristate (1 = release)
//   scl_i, sda_i             pad inputs (asynchronous, synchronised here)
//   scl_o/scl_t, sda_o/sda_t pad drive to the IOBUFs
//   owner                    index of current/last owner
//   busy                     arbiter not in IDLE
//   timeout_err              one-cycle pulse when a grant is revoked
// -----------------------------------------------------------------------------
module iic_shield_arbiter #(
  parameter int unsigned NUM_REQ         = 2,
  parameter int unsigned BUS_FREE_CYCLES = 500,
  parameter int unsigned TIMEOUT_CYCLES  = 100000,
  parameter int unsigned RECOV_HALF      = 250
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  input  logic [NUM_REQ-1:0] m_scl_o,
  input  logic [NUM_REQ-1:0] m_scl_t,
  input  logic [NUM_REQ-1:0] m_sda_o,
  input  logic [NUM_REQ-1:0] m_sda_t,
  input  logic               scl_i,
  input  logic               sda_i,
  output logic               scl_o,
  output logic               scl_t,
  output logic               sda_o,
  output logic               sda_t,
  output logic [2:0]         owner,
  output logic               busy,
  output logic               timeout_err
);

  localparam int unsigned FREE_W = $clog2(BUS_FREE_CYCLES + 1);
  localparam int unsigned LOW_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FREE_W-1:0] FREE_MAX = FREE_W'(BUS_FREE_CYCLES);
  localparam logic [LOW_W-1:0]  LOW_LAST = LOW_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
`ifdef IIC_BUS_RECOVERY_EN
    RECOVER,
`endif
    WAIT_FREE
  } state_t;

  state_t              state_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [2:0]          owner_q;
  logic [2:0]          ptr_q;
  logic                busy_q;
  logic                terr_q;

  logic                scl_s1_q, scl_s2_q;
  logic                sda_s1_q, sda_s2_q;

  logic [FREE_W-1:0]   free_q, free_d;
  logic                bus_free, free_full_d;
  logic [LOW_W-1:0]    low_q, low_d;

  logic                own_req, own_scl_o, own_scl_t, own_sda_o, own_sda_t;
  logic                own_low, timeout_hit;
  logic [2:0]          ptr_next;

  logic                pick_valid;
  logic [2:0]          pick_idx;
  logic [NUM_REQ-1:0]  pick_oh;
  int unsigned         pick_pos;

`ifdef IIC_BUS_RECOVERY_EN
  localparam int unsigned RCNT_W = $clog2(RECOV_HALF + 1);
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RECOV_HALF - 1);

  typedef enum logic [2:0] {
    R_CHECK,
    R_LOW,
    R_HIGH,
    R_STOP_A,
    R_STOP_B,
    R_STOP_C
  } rphase_t;

  rphase_t             rph_q;
  logic [RCNT_W-1:0]   rcnt_q;
  logic [3:0]          rpulse_q;
  logic                rscl_t_q, rsda_t_q;
  logic                half_done;

  assign half_done = (rcnt_q == RCNT_LAST);
`else
  logic unused_recov;
  assign unused_recov = (RECOV_HALF != 0);
`endif

  // Bus-free qualification on synchronised pad levels.
  assign bus_free = (free_q == FREE_MAX);

  always_comb begin
    free_d = '0;
    if (scl_s2_q && sda_s2_q) begin
      free_d = bus_free ? free_q : free_q + 1'b1;
    end
    free_full_d = (free_d == FREE_MAX);
  end

  // Owner mux: registered select, combinational data path.
  always_comb begin
    own_req   = 1'b0;
    own_scl_o = 1'b0;
    own_scl_t = 1'b1;
    own_sda_o = 1'b0;
    own_sda_t = 1'b1;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner_q == 3'(i)) begin
        own_req   = req[i];
        own_scl_o = m_scl_o[i];
        own_scl_t = m_scl_t[i];
        own_sda_o = m_sda_o[i];
        own_sda_t = m_sda_t[i];
      end
    end
  end

  assign own_low     = !own_scl_t && !own_scl_o;
  assign low_d       = (state_q == GRANT && own_low) ? low_q + 1'b1 : '0;
  assign timeout_hit = (state_q == GRANT) && own_low && (low_q == LOW_LAST);
  assign ptr_next    = (owner_q == 3'(NUM_REQ - 1)) ? 3'd0 : owner_q + 3'd1;

  // Round-robin pick: first requester at or after ptr_q, wrapping.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    pick_oh    = '0;
    pick_pos   = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      pick_pos = 32'(ptr_q) + off;
      if (pick_pos >= NUM_REQ) begin
        pick_pos = pick_pos - NUM_REQ;
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!pick_valid && pick_pos == i && req[i]) begin
          pick_valid = 1'b1;
          pick_idx   = 3'(i);
          pick_oh[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= WAIT_FREE;
      gnt_q    <= '0;
      owner_q  <= '0;
      ptr_q    <= '0;
      busy_q   <= 1'b0;
      terr_q   <= 1'b0;
      scl_s1_q <= 1'b0;
      scl_s2_q <= 1'b0;
      sda_s1_q <= 1'b0;
      sda_s2_q <= 1'b0;
      free_q   <= '0;
      low_q    <= '0;
`ifdef IIC_BUS_RECOVERY_EN
      rph_q    <= R_CHECK;
      rcnt_q   <= '0;
      rpulse_q <= '0;
      rscl_t_q <= 1'b1;
      rsda_t_q <= 1'b1;
`endif
    end else begin
      scl_s1_q <= scl_i;
      scl_s2_q <= scl_s1_q;
      sda_s1_q <= sda_i;
      sda_s2_q <= sda_s1_q;
      free_q   <= free_d;
      low_q    <= low_d;
      terr_q   <= 1'b0;
      busy_q   <= 1'b1;

      case (state_q)
        // Leave on the edge where the counter saturates, so IDLE already
        // sees bus_free=1 on its first cycle.
        WAIT_FREE: begin
          if (free_full_d) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end

        IDLE: begin
          if (bus_free && pick_valid) begin
            state_q <= GRANT;
            gnt_q   <= pick_oh;
            owner_q <= pick_idx;
          end else begin
            busy_q  <= 1'b0;
          end
        end

        GRANT: begin
          if (!own_req) begin
            gnt_q   <= '0;
            ptr_q   <= ptr_next;
            state_q <= WAIT_FREE;
          end else if (timeout_hit) begin
            gnt_q   <= '0;
            terr_q  <= 1'b1;
            ptr_q   <= ptr_next;
`ifdef IIC_BUS_RECOVERY_EN
            state_q  <= RECOVER;
            rph_q    <= R_CHECK;
            rcnt_q   <= '0;
            rpulse_q <= '0;
            rscl_t_q <= 1'b1;
            rsda_t_q <= 1'b1;
`else
            state_q <= WAIT_FREE;
`endif
          end
        end

`ifdef IIC_BUS_RECOVERY_EN
        RECOVER: begin
          rcnt_q <= half_done ? '0 : rcnt_q + 1'b1;
          case (rph_q)
            R_CHECK: begin
              rcnt_q <= '0;
              if (sda_s2_q) begin
                state_q <= WAIT_FREE;
              end else begin
                rph_q    <= R_LOW;
                rscl_t_q <= 1'b0;
              end
            end
            R_LOW: begin
              if (half_done) begin
                rscl_t_q <= 1'b1;
                rpulse_q <= rpulse_q + 4'd1;
                rph_q    <= R_HIGH;
              end
            end
            R_HIGH: begin
              if (half_done) begin
                rscl_t_q <= 1'b0;
                rph_q    <= (sda_s2_q || rpulse_q == 4'd9) ? R_STOP_A : R_LOW;
              end
            end
            // SDA is pulled low one cycle after SCL falls so the edge
            // cannot be mistaken for a START.
            R_STOP_A: begin
              if (rcnt_q == '0) begin
                rsda_t_q <= 1'b0;
              end
              if (half_done) begin
                rscl_t_q <= 1'b1;
                rph_q    <= R_STOP_B;
              end
            end
            R_STOP_B: begin
              if (half_done) begin
                rsda_t_q <= 1'b1;
                rph_q    <= R_STOP_C;
              end
            end
            default: begin
              if (half_done) begin
                state_q <= WAIT_FREE;
              end
            end
          endcase
        end
`endif

        default: begin
          gnt_q   <= '0;
          state_q <= WAIT_FREE;
        end
      endcase
    end
  end

  // Pad drive: released everywhere except GRANT (and recovery).
  always_comb begin
    scl_o = 1'b0;
    scl_t = 1'b1;
    sda_o = 1'b0;
    sda_t = 1'b1;
    if (state_q == GRANT) begin
      scl_o = own_scl_o;
      scl_t = own_scl_t;
      sda_o = own_sda_o;
      sda_t = own_sda_t;
    end
`ifdef IIC_BUS_RECOVERY_EN
    else if (state_q == RECOVER) begin
      scl_t = rscl_t_q;
      sda_t = rsda_t_q;
    end
`endif
  end

  assign gnt         = gnt_q;
  assign owner       = owner_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_iic_shield_arbiter.sv
module tb_iic_shield_arbiter;

  localparam int unsigned B = 8;
  localparam int unsigned T = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req, gnt;
  logic [1:0] m_scl_o, m_scl_t, m_sda_o, m_sda_t;
  logic       scl_i, sda_i, scl_o, scl_t, sda_o, sda_t;
  logic [2:0] owner;
  logic       busy, timeout_err;
  logic       scl_hold;

  int unsigned passed = 0;
  int unsigned total  = 0;

  typedef struct {
    logic [1:0] req;
    logic [1:0] mso;
    logic [1:0] mst;
    logic [1:0] mdo;
    logic [1:0] mdt;
    logic [1:0] egnt;
    logic [3:0] epad;
  } vec_t;

  vec_t vecs [7];

  iic_shield_arbiter #(
    .NUM_REQ(2),
    .BUS_FREE_CYCLES(B),
    .TIMEOUT_CYCLES(T),
    .RECOV_HALF(4)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .m_scl_o(m_scl_o), .m_scl_t(m_scl_t), .m_sda_o(m_sda_o), .m_sda_t(m_sda_t),
    .scl_i(scl_i), .sda_i(sda_i),
    .scl_o(scl_o), .scl_t(scl_t), .sda_o(sda_o), .sda_t(sda_t),
    .owner(owner), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Pulled-up open-drain pads; scl_hold models an external device holding SCL.
  assign scl_i = scl_hold ? 1'b0 : (scl_t ? 1'b1 : scl_o);
  assign sda_i = sda_t ? 1'b1 : sda_o;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic release_masters();
    m_scl_o = '0; m_scl_t = '1; m_sda_o = '0; m_sda_t = '1;
  endtask

  task automatic wait_gnt(input logic [1:0] exp, input string name);
    int unsigned n = 0;
    while (gnt == '0 && n < 4 * B + 10) begin
      tick();
      n++;
    end
    check(name, 32'(gnt), 32'(exp));
  endtask

  // Bus becomes idle just before edge 1: IDLE at edge B+2, grant at edge B+3.
  task automatic exact_grant(input logic [1:0] exp, input string name);
    int unsigned early = 0;
    for (int unsigned n = 1; n <= B + 3; n++) begin
      tick();
      if (n < B + 3 && gnt != '0) early++;
      if (n == B + 2) check({name, "_idle_busy"}, 32'(busy), 32'd0);
    end
    check({name, "_early"}, early, 0);
    check({name, "_gnt"}, 32'(gnt), 32'(exp));
    check({name, "_busy"}, 32'(busy), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned nogrant;
    vecs[0] = '{2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b10, 4'b0101};
    vecs[1] = '{2'b11, 2'b00, 2'b01, 2'b00, 2'b11, 2'b10, 4'b0001};
    vecs[2] = '{2'b11, 2'b00, 2'b11, 2'b00, 2'b10, 2'b10, 4'b0101};
    vecs[3] = '{2'b11, 2'b00, 2'b11, 2'b10, 2'b01, 2'b10, 4'b0110};
    vecs[4] = '{2'b11, 2'b10, 2'b01, 2'b01, 2'b00, 2'b10, 4'b1000};
    vecs[5] = '{2'b11, 2'b01, 2'b10, 2'b00, 2'b10, 2'b10, 4'b0101};
    vecs[6] = '{2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b10, 4'b0101};

    req = 2'b01;
    scl_hold = 1'b0;
    release_masters();

    // Reset values
    tick(); tick();
    check("rst_gnt", 32'(gnt), 0);
    check("rst_pads", {28'd0, scl_o, scl_t, sda_o, sda_t}, 32'b0101);
    check("rst_owner", 32'(owner), 0);
    check("rst_busy_terr", {30'd0, busy, timeout_err}, 0);

    // First grant latency after reset
    rst = 1'b0;
    exact_grant(2'b01, "reset_to_grant");
    check("owner0", 32'(owner), 0);
    m_scl_t = 2'b10;
    #1 check("scl_t_follows_m0", 32'(scl_t), 0);
    m_scl_t = 2'b01;
    #1 check("scl_t_ignores_m1", 32'(scl_t), 1);
    release_masters();

    // Drop request: grant and pads released on the next edge
    req = 2'b00;
    tick();
    check("drop_gnt", 32'(gnt), 0);
    check("drop_scl_t", 32'(scl_t), 1);

    req = 2'b10;
    wait_gnt(2'b10, "grant_m1");

    // Owner 1 active, master 0 requests and wiggles its lines
    for (int unsigned k = 0; k < 7; k++) begin
      req = vecs[k].req;
      m_scl_o = vecs[k].mso; m_scl_t = vecs[k].mst;
      m_sda_o = vecs[k].mdo; m_sda_t = vecs[k].mdt;
      #1;
      check($sformatf("vec%0d", k), {26'd0, gnt, scl_o, scl_t, sda_o, sda_t},
            {26'd0, vecs[k].egnt, vecs[k].epad});
      tick();
    end
    release_masters();

    // Pointer wraps to 0; both request together
    req = 2'b00;
    tick();
    check("wrap_drop_gnt", 32'(gnt), 0);
    req = 2'b11;
    wait_gnt(2'b01, "rr_both_ptr0");
    req = 2'b10;
    tick();
    check("rr_handover_gap", 32'(gnt), 0);
    wait_gnt(2'b10, "rr_next_m1");

    // SCL held low by owner: revoke after exactly T low cycles
    m_scl_t = 2'b01; m_scl_o = 2'b00;
    for (int unsigned n = 1; n < T; n++) tick();
    check("to_before_gnt", {30'd0, gnt}, 32'b10);
    check("to_before_err", 32'(timeout_err), 0);
    tick();
    check("to_err_pulse", 32'(timeout_err), 1);
    check("to_gnt", 32'(gnt), 0);
    check("to_scl_t", 32'(scl_t), 1);
    check("to_owner_last", 32'(owner), 1);
    tick();
    check("to_err_one_cycle", 32'(timeout_err), 0);
    release_masters();

    // Request drop and timeout in the same cycle: drop wins
    wait_gnt(2'b10, "regrant_m1");
    m_scl_t = 2'b01; m_scl_o = 2'b00;
    for (int unsigned n = 1; n < T; n++) tick();
    req = 2'b00;
    tick();
    check("tie_gnt", 32'(gnt), 0);
    check("tie_no_err", 32'(timeout_err), 0);
    tick();
    check("tie_no_late_err", 32'(timeout_err), 0);
    release_masters();

    // Asynchronous reset during a transfer
    req = 2'b01;
    wait_gnt(2'b01, "pre_rst_grant");
    m_scl_t = 2'b10; m_sda_t = 2'b10;
    #1 check("pre_rst_pads", {30'd0, scl_t, sda_t}, 0);
    #2 rst = 1'b1;
    #1 check("async_rst", {29'd0, gnt, scl_t, sda_t}, 32'b0011);
    check("async_rst_busy", 32'(busy), 0);
    release_masters();
    tick(); tick();
    scl_hold = 1'b1;
    rst = 1'b0;
    nogrant = 0;
    for (int unsigned n = 0; n < 3 * B; n++) begin
      tick();
      if (gnt != '0) nogrant++;
    end
    check("no_grant_bus_busy", nogrant, 0);
    scl_hold = 1'b0;
    exact_grant(2'b01, "hold_release_grant");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
